// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the mux4 round-robin arbiter slice.
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned W_DEF    = 4;
  localparam logic [1:0]  LAST_RST = 2'd3;
  localparam int unsigned CNT_W    = 8;

  // One-hot decode of a 2-bit requester index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle for mux4_rr_arbiter.
// master = requesters + downstream consumer, slave = arbiter.
interface mux4_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int unsigned W = W_DEF
);

  logic [3:0]   req;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic [3:0]   ack;
  logic [1:0]   sel;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic         to_err;

  modport master (
    output req, d0, d1, d2, d3, out_ready,
    input  ack, sel, y, out_valid, to_err
  );

  modport slave (
    input  req, d0, d1, d2, d3, out_ready,
    output ack, sel, y, out_valid, to_err
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way rotating priority picker: searches last+1, last+2,
// last+3, last (mod 4) and reports the first set request.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] win
);

  logic       found;
  logic [1:0] idx;

  // Walk the rotated priority order; the 2-bit index wraps naturally.
  always_comb begin
    win   = last;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Any pending request at all.
  always_comb begin
    any = |req;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four requesters,
// presenting the selected word on a valid/ready handshake.
// Optional feature: define ARB_TIMEOUT_EN to drop a word stalled for
// TIMEOUT cycles and pulse to_err; otherwise to_err is tied low.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  mux4_rr_arbiter_if.slave  bus
);

  if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_timeout_range_err
    $error("mux4_rr_arbiter: TIMEOUT must be in 1..255");
  end

  state_t       state_q, state_d;
  logic [1:0]   last_q, last_d;
  logic [1:0]   sel_q, sel_d;
  logic [W-1:0] y_q, y_d;
  logic         out_valid_q, out_valid_d;

  logic         pick_any;
  logic [1:0]   pick_win;
  logic [W-1:0] d_sel;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             to_err_q, to_err_d;
`endif

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (last_q),
    .any  (pick_any),
    .win  (pick_win)
  );

  // Shared 4:1 data mux steered by the picker's candidate winner.
  always_comb begin
    d_sel = '0;
    case (pick_win)
      2'd0: d_sel = bus.d0;
      2'd1: d_sel = bus.d1;
      2'd2: d_sel = bus.d2;
      2'd3: d_sel = bus.d3;
      default: d_sel = '0;
    endcase
  end

  // Next-state: grant in IDLE, hold until accepted (or timed out) in BUSY.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
`ifdef ARB_TIMEOUT_EN
    stall_d     = '0;
    to_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d       = pick_win;
          y_d         = d_sel;
          out_valid_d = 1'b1;
          last_d      = pick_win;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // An accept on the final stalled cycle wins over the timeout.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (stall_q == CNT_W'(TIMEOUT)) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          to_err_d    = 1'b1;
        end else begin
          stall_d = stall_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= LAST_RST;
      sel_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      stall_q     <= '0;
      to_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
`ifdef ARB_TIMEOUT_EN
      stall_q     <= stall_d;
      to_err_q    <= to_err_d;
`endif
    end
  end

  // Output drive; ack is zero-latency on the accepting cycle.
  always_comb begin
    bus.sel       = sel_q;
    bus.y         = y_q;
    bus.out_valid = out_valid_q;
    bus.ack       = (out_valid_q && bus.out_ready) ? onehot4(sel_q) : '0;
`ifdef ARB_TIMEOUT_EN
    bus.to_err    = to_err_q;
`else
    bus.to_err    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter against a behavioural model.
module tb_mux4_rr_arbiter;

  localparam int unsigned TO = 3;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
  localparam int BP_STALLS  = 3;
`else
  localparam bit TIMEOUT_ON = 1'b0;
  localparam int BP_STALLS  = 5;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_r;
  logic [3:0] dv [4];
  logic       rdy;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit         m_busy;
  int         m_last;
  int         m_sel;
  logic [3:0] m_y;
  bit         m_valid;
  bit         m_toerr;
  int         m_stall;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if #(.W(4)) bus ();

  assign bus.req       = req_r;
  assign bus.d0        = dv[0];
  assign bus.d1        = dv[1];
  assign bus.d2        = dv[2];
  assign bus.d3        = dv[3];
  assign bus.out_ready = rdy;

  mux4_rr_arbiter #(.W(4), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [3:0] exp_ack();
    return (m_valid && rdy) ? 4'(1 << m_sel) : 4'b0000;
  endfunction

  function automatic logic [7:0] exp_out();
    return {m_valid, 2'(m_sel), m_y, m_toerr};
  endfunction

  function automatic logic [7:0] got_out();
    return {bus.out_valid, bus.sel, bus.y, bus.to_err};
  endfunction

  // Advance the model by one rising edge using the current inputs.
  function automatic void model_step();
    if (rst) begin
      m_busy = 0; m_last = 3; m_sel = 0; m_y = '0;
      m_valid = 0; m_toerr = 0; m_stall = 0;
    end else begin
      m_toerr = 0;
      if (!m_busy) begin
        if (req_r != 4'b0000) begin
          for (int k = 1; k <= 4; k++) begin
            int w = (m_last + k) % 4;
            if (req_r[w]) begin
              m_sel = w;
              break;
            end
          end
          m_y = dv[m_sel]; m_last = m_sel;
          m_valid = 1; m_busy = 1; m_stall = 0;
        end
      end else if (rdy) begin
        m_valid = 0; m_busy = 0; m_stall = 0;
      end else if (TIMEOUT_ON && m_stall == int'(TO)) begin
        m_valid = 0; m_busy = 0; m_stall = 0; m_toerr = 1;
      end else begin
        m_stall++;
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b0; req_r = '0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_r = 4'hF; rdy = 1'b0;
    dv[0] = 4'd1; dv[1] = 4'd2; dv[2] = 4'd3; dv[3] = 4'd4;
    cycle();
    cycle();
    total++;
    if ({bus.out_valid, bus.y, bus.sel, bus.ack} !== 11'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%0b y=%h sel=%0d ack=%b want all zero",
               bus.out_valid, bus.y, bus.sel, bus.ack);
    end
    rst = 1'b0; rdy = 1'b1;
    cycle();
    total++;
    if ({bus.out_valid, bus.sel} !== 3'b100) begin
      bad++;
      $display("FAIL reset_first_grant: got v=%0b sel=%0d want v=1 sel=0",
               bus.out_valid, bus.sel);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_y [5];
    exp_y = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    req_r = 4'hF; rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({bus.out_valid, bus.y} !== {1'b1, exp_y[i]}) begin
        bad++;
        $display("FAIL rr_word%0d: got v=%0b y=%h want v=1 y=%h",
                 i, bus.out_valid, bus.y, exp_y[i]);
      end
      total++;
      if (bus.ack !== 4'(1 << (i % 4))) begin
        bad++;
        $display("FAIL rr_ack%0d: got %b want %b", i, bus.ack, 4'(1 << (i % 4)));
      end
      cycle();
      total++;
      if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
        bad++;
        $display("FAIL rr_gap%0d: got v=%0b ack=%b want v=0 ack=0000",
                 i, bus.out_valid, bus.ack);
      end
      cycle();
    end
  endtask

  task automatic test_rotation_skip();
    do_reset();
    req_r = 4'b0010; rdy = 1'b0;
    cycle();
    total++;
    if (bus.sel !== 2'd1) begin
      bad++;
      $display("FAIL skip_first: got sel=%0d want 1", bus.sel);
    end
    req_r = 4'b0011; rdy = 1'b1;
    cycle();
    cycle();
    total++;
    if (bus.sel !== 2'd0 || got_out() !== exp_out()) begin
      bad++;
      $display("FAIL skip_to0: got sel=%0d out=%h want sel=0 out=%h",
               bus.sel, got_out(), exp_out());
    end
    cycle();
    cycle();
    total++;
    if (bus.sel !== 2'd1 || got_out() !== exp_out()) begin
      bad++;
      $display("FAIL skip_to1: got sel=%0d out=%h want sel=1 out=%h",
               bus.sel, got_out(), exp_out());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_r = 4'b0100; dv[2] = 4'hA; rdy = 1'b0;
    cycle();
    dv[2] = 4'h5; req_r = 4'b0000;
    for (int i = 0; i < BP_STALLS; i++) begin
      #1;
      total++;
      if (bus.ack !== 4'b0000) begin
        bad++;
        $display("FAIL bp_ack_stall%0d: got %b want 0000", i, bus.ack);
      end
      cycle();
      total++;
      if ({bus.out_valid, bus.sel, bus.y, bus.to_err} !== {1'b1, 2'd2, 4'hA, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%0b sel=%0d y=%h err=%0b want v=1 sel=2 y=a err=0",
                 i, bus.out_valid, bus.sel, bus.y, bus.to_err);
      end
    end
    rdy = 1'b1;
    #1;
    total++;
    if (bus.ack !== 4'b0100) begin
      bad++;
      $display("FAIL bp_ack_accept: got %b want 0100", bus.ack);
    end
    cycle();
    total++;
    if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000 || bus.to_err !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: got v=%0b ack=%b err=%0b want 0 0000 0",
               bus.out_valid, bus.ack, bus.to_err);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_r = 4'b0010; rdy = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    total++;
    if (bus.ack !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_ack: got %b want 0000", bus.ack);
    end
    cycle();
    rst = 1'b0;
    total++;
    if ({bus.out_valid, bus.ack, bus.to_err} !== 6'b0) begin
      bad++;
      $display("FAIL midrst_state: got v=%0b ack=%b err=%0b want all zero",
               bus.out_valid, bus.ack, bus.to_err);
    end
    req_r = 4'hF;
    cycle();
    total++;
    if ({bus.out_valid, bus.sel} !== 3'b100) begin
      bad++;
      $display("FAIL midrst_regrant: got v=%0b sel=%0d want v=1 sel=0",
               bus.out_valid, bus.sel);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_r = 4'b0001; rdy = 1'b0;
    cycle();
    req_r = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (bus.to_err !== 1'b0 || bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL to_stall%0d: got err=%0b v=%0b want err=0 v=1",
                 i, bus.to_err, bus.out_valid);
      end
    end
    cycle();
    total++;
    if (bus.to_err !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL to_drop: got err=%0b v=%0b want err=1 v=0",
               bus.to_err, bus.out_valid);
    end
    req_r = 4'b0011;
    cycle();
    total++;
    if (bus.to_err !== 1'b0 || bus.sel !== 2'd1) begin
      bad++;
      $display("FAIL to_after: got err=%0b sel=%0d want err=0 sel=1",
               bus.to_err, bus.sel);
    end
    do_reset();
    req_r = 4'b0001; rdy = 1'b0;
    cycle();
    req_r = 4'b0000;
    cycle();
    cycle();
    rdy = 1'b1;
    #1;
    total++;
    if (bus.ack !== 4'b0001) begin
      bad++;
      $display("FAIL to_late_ack: got %b want 0001", bus.ack);
    end
    cycle();
    total++;
    if (bus.to_err !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL to_late_noerr: got err=%0b v=%0b want 0 0",
               bus.to_err, bus.out_valid);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req_r = 4'($urandom);
      rdy   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) rdy = 1'b0;
      for (int j = 0; j < 4; j++) dv[j] = 4'($urandom);
      rst   = ($urandom_range(0, 59) == 0);
      #1;
      total++;
      if (bus.ack !== exp_ack()) begin
        bad++;
        $display("FAIL rand_ack%0d: got %b want %b", n, bus.ack, exp_ack());
      end
      cycle();
      total++;
      if (got_out() !== exp_out()) begin
        bad++;
        $display("FAIL rand_out%0d: got {v,sel,y,err}=%h want %h", n, got_out(), exp_out());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_r = '0; rdy = 1'b0;
    for (int j = 0; j < 4; j++) dv[j] = '0;
    m_busy = 0; m_last = 3; m_sel = 0; m_y = '0;
    m_valid = 0; m_toerr = 0; m_stall = 0;
    test_reset();
    test_round_robin();
    test_rotation_skip();
    test_backpressure();
    test_mid_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin controller that shares one 4-input, 4-bit data mux among four requesters and presents the selected word to a single downstream consumer through a valid/ready handshake. It picks a winner from the pending requests and drives the mux select. It registers the selected word, holds it until the consumer accepts it, and acknowledges the winning requester. It sits between the comparator front-end sources and the shared result path.

## Interface
Parameters:
- W, 4, data width of each requester word and of the output.
- TIMEOUT, 15, number of consecutive stalled cycles before a pending word is dropped. Used only when ARB_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  in  4  req[i] high = requester i has a word pending on d_i.
- d0, d1, d2, d3  in  W each  requester data words.
- ack  out  4  one-hot, combinational: ack[i] = out_valid & out_ready & (sel == i).
- sel  out  2  registered mux select; equals the index of the current grant.
- y  out  W  registered selected word.
- out_valid  out  1  y holds an unaccepted word.
- out_ready  in  1  consumer accepts y on any cycle where out_valid & out_ready.
- to_err  out  1  one-cycle pulse when a word is dropped on timeout. Tied 0 when ARB_TIMEOUT_EN is undefined.

## Operation
- FSM with two states, IDLE and BUSY.
- Round-robin pointer last[1:0] holds the index of the most recent winner.
- IDLE:
  - If req == 0, remain in IDLE.
  - Otherwise the winner is the first set req bit, searching in the order last+1, last+2, last+3, last (mod 4).
  - Next edge: sel <= winner, y <= d_winner, out_valid <= 1, last <= winner, state <= BUSY.
- BUSY:
  - sel and y are held stable.
  - On an edge with out_ready = 1: out_valid <= 0 and state <= IDLE.
  - ack[sel] is high during that same cycle.
- Requesters:
  - A requester must drop or refresh req on the edge after it sees its ack.
  - req changes during BUSY are ignored.
  - The word is captured at grant, so d_i may change after the grant edge.
- Fairness: a continuously requesting source waits at most 3 other transfers.
- Reset, as the synchronous-reset values:
  - state = IDLE
  - last = 3, so requester 0 has first priority
  - sel = 0, y = 0, out_valid = 0, to_err = 0, stall counter = 0
  - ack = 0, since out_valid = 0
- Reset asserted in BUSY abandons the word with no ack and no to_err.

## Timing
- Grant latency: req sampled in IDLE at edge N; out_valid = 1 with valid y/sel from edge N onward.
- Minimum transfer period is 2 cycles (BUSY, then IDLE), so sustained throughput is 1 word per 2 cycles.
- If out_ready is held high, each grant occupies exactly one BUSY cycle.
- ack has zero latency relative to the accepting cycle and is never high outside BUSY.
- A simultaneous req rise and ack for a different requester has no effect in that cycle; the new req is evaluated in the following IDLE cycle.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit stall counter increments on each BUSY cycle with out_ready = 0 and clears on leaving BUSY.
  - When the counter reaches TIMEOUT with out_ready still 0, the next edge sets out_valid <= 0, state <= IDLE and to_err <= 1 for one cycle.
  - No ack is issued; last keeps the dropped winner, so that requester goes to lowest priority.
  - If out_ready = 1 on that final cycle, the normal transfer takes precedence and no error is raised.
- ARB_TIMEOUT_EN undefined: no counter is built, to_err is constant 0, and BUSY waits indefinitely.

## Structure
- Shared package mux_arb_pkg:
  - state type {IDLE, BUSY}
  - default width W_DEF = 4
  - reset pointer value LAST_RST = 2'd3
  - counter width CNT_W = 8
- Sub-module rr_pick4: combinational 4-way rotating priority picker.
  - Inputs: req[3:0], last[1:0].
  - Outputs: any, win[1:0].
  - Verified standalone against all 64 input combinations.
- Top level contains the FSM, the output registers, the stall counter and the 4:1 data selection.

## Test plan
- Reset: assert rst for 2 cycles with req = 4'hF → out_valid = 0, y = 0, sel = 0, ack = 0. After release, the first grant goes to sel = 0.
- Round robin: req = 4'hF held, out_ready = 1, d0..d3 = 1, 2, 3, 4 → y sequence 1, 2, 3, 4, 1, with out_valid high every other cycle and ack = 0001, 0010, 0100, 1000.
- Rotation skip: after a grant to 1, req = 4'b0011 → next grant 0, then 1.
- Backpressure: grant 2 with d2 = 4'hA, out_ready = 0 for 5 cycles → y stays A and sel stays 2. Changing d2 does not alter y. ack[2] rises only in the cycle out_ready = 1.
- Mid-operation reset: rst in BUSY → next cycle out_valid = 0, no ack, and the next grant goes to 0.
- ARB_TIMEOUT_EN, TIMEOUT = 3: out_ready held 0 → to_err pulses once after 3 stalled cycles and out_valid falls. A second run raises out_ready on the 3rd stalled cycle → normal ack, no to_err.
